gsim_band_solver: RTL and testbench
===================================

// Module: gsim_band_solver
// PURPOSE
//  Parametrised Gauss-Seidel solver for the N x N banded system whose row i is
//  20*x[i] -13*(x[i-1]+x[i+1]) +6*(x[i-2]+x[i+2]) -(x[i-3]+x[i+3]) = b[i].
//  Out-of-range neighbours are 0. Successor to the fixed 16-row/70-iteration solver.
//  Adds generic N/widths, runtime iteration count, tolerance-based early exit and
//  ready/valid handshakes with output backpressure. Sits between the b-stream source
//  and the x-result sink.
// PARAMETERS
//  N        16  rows per problem (>=4)
//  B_W      16  signed integer width of b
//  X_W      32  signed fixed-point width of x
//  FRAC     16  fraction bits of x
//  ITER_W    8  width of cfg_iter / out_iters
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      synchronous, active-low reset
//  in_valid     in   1      b_in valid
//  in_ready     out  1      solver accepts b
//  b_in         in   B_W    b[i], signed, rows in order 0..N-1
//  cfg_iter     in   ITER_W max iterations; sampled on row-0 accept; 0 = 1 iteration
//  cfg_early_en in   1      early-exit enable; sampled on row-0 accept
//  cfg_tol      in   X_W    early-exit threshold (unsigned); sampled on row-0 accept
//  out_valid    out  1      x_out valid
//  out_ready    in   1      sink accepts x_out
//  x_out        out  X_W    x[i], signed Q(X_W-FRAC).FRAC, rows in order 0..N-1
//  out_last     out  1      high with x[N-1]
//  out_iters    out  ITER_W iterations executed; stable while out_valid
//  out_conv     out  1      1 = ended by tolerance; stable while out_valid
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, counters=0; in_ready=0,
//   out_valid=0, out_last=0, x_out=0, out_iters=0, out_conv=0. Holds mid-operation;
//   partial problem discarded. b/x arrays need no reset.
//  States: IDLE, LOAD, CALC, OUT.
//   IDLE: in_ready=1. A handshake stores b[0] and the cfg_* fields, clears all x to 0,
//    and moves to LOAD (for N=1 it would go to CALC; N>=4 is enforced).
//   LOAD: in_ready=1. Each handshake stores the next row. After the row N-1 handshake,
//    in_ready drops in the same cycle and the next state is CALC. in_valid is ignored
//    when in_ready=0.
//   CALC: one row per cycle, r = 0..N-1. x[r] is written at the cycle's edge, so row r+1
//    sees the updated x[r] (true Gauss-Seidel).
//    - Track maxd = max |x_new - x_old| over the iteration; reset maxd at r=0.
//    - After row N-1: iters += 1. Go to OUT if iters == max(cfg_iter,1), or if
//      cfg_early_en && maxd <= cfg_tol (then out_conv=1). Otherwise restart at r=0.
//    - If both exit conditions hold, out_conv=1.
//   OUT: out_valid=1, x_out = x[idx], starting with idx=0. idx advances only on
//    out_valid && out_ready. With out_ready=0, x_out/out_last are held.
//    After the idx=N-1 handshake: out_valid=0 and next state is IDLE.
//  Latency: with the last b accepted at cycle t, out_valid first rises at cycle
//   t+iters*N+1. The first new b is accepted no earlier than the cycle after the
//   last output handshake.
//  Arithmetic (row update, signed):
//   s = (b<<<FRAC) + 13*(xm1+xp1) - 6*(xm2+xp2) + (xm3+xp3), in ACC_W = X_W+6 bits.
//   x_new = (s * 3277) >>> 16, i.e. reciprocal of 20 with floor rounding.
//   The result saturates to the signed X_W range.
// STRUCTURE
//  gsim_pkg.vh holds:
//   - coefficients C1=13, C2=6, C3=1
//   - RECIP=3277, RECIP_SH=16
//   - state encodings
//   - ACC_W formula
//  Sub-module gsim_row_pe is the combinational row update: six neighbours + b -> x_new,
//   plus |x_new - x_old|. The top holds the FSM, counters, b/x register arrays and
//   handshakes.
// TESTING (golden model: bit-exact C/Python of the arithmetic above)
//  1. N=16, cfg_iter=0, b[0]=20, others 0
//     -> out_iters=1, x[0]=0x00010004, x[1]=0x0000A66B, out_conv=0.
//  2. b all 0, cfg_iter=5
//     -> 16 outputs of 0, out_last only on 16th, out_iters=5, first out_valid
//        exactly 81 cycles after last b accept.
//  3. Random b, cfg_iter=70, early off; out_ready random 50%
//     -> bit-exact vs model, each x exactly once in order, x_out held while stalled.
//  4. b all 100, cfg_iter=200, early on, cfg_tol=0x10
//     -> out_conv=1, out_iters < 200 and equal to the model's iteration count.
//  5. in_valid gaps during LOAD, and in_valid high during CALC/OUT
//     -> no extra rows accepted, in_ready=0 outside IDLE/LOAD.
//  6. rst_n=0 for 1 cycle at row 7 of iteration 3
//     -> next cycle IDLE, all outputs at reset values; a following problem matches
//        the model.

Source files
------------

// File: rtl/gsim_band_solver_pkg.sv
// Shared constants, state encoding and width helper for the banded Gauss-Seidel solver.
package gsim_band_solver_pkg;

  localparam int C1        = 13;
  localparam int C2        = 6;
  localparam int C3        = 1;
  localparam int RECIP     = 3277;
  localparam int RECIP_SH  = 16;
  localparam int ACC_EXTRA = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_OUT
  } state_t;

  // Accumulator headroom covers b<<FRAC plus 13*2x + 6*2x + 2x without overflow.
  function automatic int acc_w(input int x_w);
    return x_w + ACC_EXTRA;
  endfunction

endpackage

// File: rtl/gsim_band_solver_row_pe.sv
// Combinational row update: weighted neighbours plus b, times 1/20 with floor rounding,
// saturated to the x range, plus the magnitude of the change against the old value.
module gsim_band_solver_row_pe
  import gsim_band_solver_pkg::*;
#(
  parameter int B_W  = 16,
  parameter int X_W  = 32,
  parameter int FRAC = 16
) (
  input  logic [B_W-1:0] b,
  input  logic [X_W-1:0] xm1,
  input  logic [X_W-1:0] xm2,
  input  logic [X_W-1:0] xm3,
  input  logic [X_W-1:0] xp1,
  input  logic [X_W-1:0] xp2,
  input  logic [X_W-1:0] xp3,
  input  logic [X_W-1:0] x_old,
  output logic [X_W-1:0] x_new,
  output logic [X_W:0]   delta
);

  localparam int ACC_W  = acc_w(X_W);
  localparam int PROD_W = ACC_W + 14;

  localparam logic signed [ACC_W-1:0]  K1   = ACC_W'(C1);
  localparam logic signed [ACC_W-1:0]  K2   = ACC_W'(C2);
  localparam logic signed [ACC_W-1:0]  K3   = ACC_W'(C3);
  localparam logic signed [PROD_W-1:0] KR   = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] XMAX = {{(PROD_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] XMIN = {{(PROD_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] ext(input logic [X_W-1:0] v);
    return {{(ACC_W-X_W){v[X_W-1]}}, v};
  endfunction

  logic signed [ACC_W-1:0]  bs;
  logic signed [ACC_W-1:0]  s;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] q;
  logic signed [X_W:0]      dx;

  always_comb begin
    bs    = {{(ACC_W-B_W){b[B_W-1]}}, b} << FRAC;
    s     = bs + K1 * (ext(xm1) + ext(xp1)) - K2 * (ext(xm2) + ext(xp2))
               + K3 * (ext(xm3) + ext(xp3));
    prod  = $signed({{(PROD_W-ACC_W){s[ACC_W-1]}}, s}) * KR;
    // Arithmetic shift of the signed product gives floor rounding.
    q     = prod >>> RECIP_SH;
    if (q > XMAX)
      x_new = XMAX[X_W-1:0];
    else if (q < XMIN)
      x_new = XMIN[X_W-1:0];
    else
      x_new = q[X_W-1:0];
    dx    = $signed({x_new[X_W-1], x_new}) - $signed({x_old[X_W-1], x_old});
    delta = dx[X_W] ? $unsigned(-dx) : $unsigned(dx);
  end

endmodule

// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for the banded system: loads N rows of b, iterates in place one row
// per cycle until the iteration limit or the tolerance is met, then streams x out.
module gsim_band_solver
  import gsim_band_solver_pkg::*;
#(
  parameter int N      = 16,
  parameter int B_W    = 16,
  parameter int X_W    = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [B_W-1:0]    b_in,
  input  logic [ITER_W-1:0] cfg_iter,
  input  logic              cfg_early_en,
  input  logic [X_W-1:0]    cfg_tol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_W-1:0]    x_out,
  output logic              out_last,
  output logic [ITER_W-1:0] out_iters,
  output logic              out_conv
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t            state;
  logic [IDX_W-1:0]  row;
  logic [IDX_W-1:0]  row_inc;
  logic [ITER_W-1:0] iters;
  logic [ITER_W-1:0] iters_n;
  logic [ITER_W-1:0] iter_lim;
  logic              early_en;
  logic [X_W-1:0]    tol;
  logic [X_W:0]      maxd;
  logic [X_W:0]      maxd_cur;
  logic [X_W:0]      delta;
  logic              conv_hit;
  logic              in_fire;
  logic              out_fire;

  logic [B_W-1:0] b_mem [N];
  logic [X_W-1:0] x_mem [N];

  logic [X_W-1:0] xm1, xm2, xm3, xp1, xp2, xp3, x_new;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Lower neighbours already hold this iteration's values, upper ones the previous.
  always_comb begin
    xm1 = '0;
    xm2 = '0;
    xm3 = '0;
    xp1 = '0;
    xp2 = '0;
    xp3 = '0;
    for (int k = 0; k < N; k++) begin
      if (k == int'(row) - 1) xm1 = x_mem[k];
      if (k == int'(row) - 2) xm2 = x_mem[k];
      if (k == int'(row) - 3) xm3 = x_mem[k];
      if (k == int'(row) + 1) xp1 = x_mem[k];
      if (k == int'(row) + 2) xp2 = x_mem[k];
      if (k == int'(row) + 3) xp3 = x_mem[k];
    end
  end

  always_comb begin
    row_inc  = row + IDX_W'(1);
    iters_n  = iters + ITER_W'(1);
    maxd_cur = (row == '0 || delta > maxd) ? delta : maxd;
    conv_hit = early_en && (maxd_cur <= {1'b0, tol});
  end

  gsim_band_solver_row_pe #(
    .B_W  (B_W),
    .X_W  (X_W),
    .FRAC (FRAC)
  ) u_pe (
    .b     (b_mem[row]),
    .xm1   (xm1),
    .xm2   (xm2),
    .xm3   (xm3),
    .xp1   (xp1),
    .xp2   (xp2),
    .xp3   (xp3),
    .x_old (x_mem[row]),
    .x_new (x_new),
    .delta (delta)
  );

  // Data arrays carry no reset; a new problem clears x when row 0 is accepted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_IDLE && in_fire) begin
        b_mem[0] <= b_in;
        for (int k = 0; k < N; k++) x_mem[k] <= '0;
      end else if (state == ST_LOAD && in_fire) begin
        b_mem[row] <= b_in;
      end else if (state == ST_CALC) begin
        x_mem[row] <= x_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      iters     <= '0;
      iter_lim  <= '0;
      early_en  <= 1'b0;
      tol       <= '0;
      maxd      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      x_out     <= '0;
      out_iters <= '0;
      out_conv  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            iter_lim <= (cfg_iter == '0) ? ITER_W'(1) : cfg_iter;
            early_en <= cfg_early_en;
            tol      <= cfg_tol;
            iters    <= '0;
            row      <= IDX_W'(1);
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_fire) begin
            if (row == LAST) begin
              in_ready <= 1'b0;
              row      <= '0;
              state    <= ST_CALC;
            end else begin
              row <= row_inc;
            end
          end
        end
        ST_CALC: begin
          maxd <= maxd_cur;
          if (row == LAST) begin
            iters <= iters_n;
            row   <= '0;
            if (iters_n == iter_lim || conv_hit) begin
              state     <= ST_OUT;
              out_valid <= 1'b1;
              x_out     <= x_mem[0];
              out_last  <= 1'b0;
              out_iters <= iters_n;
              out_conv  <= conv_hit;
            end
          end else begin
            row <= row_inc;
          end
        end
        ST_OUT: begin
          if (out_fire) begin
            if (row == LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              row       <= '0;
              state     <= ST_IDLE;
            end else begin
              row      <= row_inc;
              x_out    <= x_mem[row_inc];
              out_last <= (row_inc == LAST);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_band_solver.sv
// Scoreboard bench for gsim_band_solver: a bit-exact model fills an expected queue at load
// time and every output handshake is popped and compared.
module tb_gsim_band_solver;

  localparam int N      = 16;
  localparam int B_W    = 16;
  localparam int X_W    = 32;
  localparam int FRAC   = 16;
  localparam int ITER_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [B_W-1:0]    b_in = '0;
  logic [ITER_W-1:0] cfg_iter = '0;
  logic              cfg_early_en = 1'b0;
  logic [X_W-1:0]    cfg_tol = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [X_W-1:0]    x_out;
  logic              out_last;
  logic [ITER_W-1:0] out_iters;
  logic              out_conv;

  always #5 clk = ~clk;

  gsim_band_solver #(
    .N(N), .B_W(B_W), .X_W(X_W), .FRAC(FRAC), .ITER_W(ITER_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .b_in         (b_in),
    .cfg_iter     (cfg_iter),
    .cfg_early_en (cfg_early_en),
    .cfg_tol      (cfg_tol),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .x_out        (x_out),
    .out_last     (out_last),
    .out_iters    (out_iters),
    .out_conv     (out_conv)
  );

  typedef struct {
    logic [31:0] x;
    logic        last;
    logic [7:0]  iters;
    logic        conv;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept_cyc = 0;

  logic signed [15:0] bvec [N];
  logic [7:0]         cfg_iter_v;
  logic               cfg_early_v;
  logic [31:0]        cfg_tol_v;

  longint      mx [N];
  logic [31:0] exp_x [N];
  int          exp_iters;
  logic        exp_conv;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint nb(input int k);
    return (k >= 0 && k < N) ? mx[k] : 64'sd0;
  endfunction

  // Reference solver written straight from the row equation in 64-bit integers.
  task automatic model_run();
    longint s, xn, d, md;
    int     lim;
    bit     stop;
    lim = (cfg_iter_v == 0) ? 1 : int'(cfg_iter_v);
    for (int k = 0; k < N; k++) mx[k] = 0;
    exp_iters = 0;
    exp_conv  = 1'b0;
    stop      = 0;
    while (!stop) begin
      md = 0;
      for (int r = 0; r < N; r++) begin
        s  = longint'(bvec[r]) * 65536;
        s  = s + 13 * (nb(r - 1) + nb(r + 1)) - 6 * (nb(r - 2) + nb(r + 2))
               + (nb(r - 3) + nb(r + 3));
        xn = (s * 3277) >>> 16;
        if (xn > 64'sd2147483647) xn = 64'sd2147483647;
        if (xn < -64'sd2147483648) xn = -64'sd2147483648;
        d = xn - mx[r];
        if (d < 0) d = -d;
        if (d > md) md = d;
        mx[r] = xn;
      end
      exp_iters++;
      exp_conv = cfg_early_v && (md <= longint'(cfg_tol_v));
      if (exp_iters == lim || exp_conv) stop = 1;
    end
    for (int k = 0; k < N; k++) exp_x[k] = 32'(mx[k]);
  endtask

  task automatic applyStimulus(input bit gaps);
    int n;
    model_run();
    for (int r = 0; r < N; r++)
      sb.push_back('{x: exp_x[r], last: (r == N - 1), iters: 8'(exp_iters), conv: exp_conv});
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    cfg_iter     = cfg_iter_v;
    cfg_early_en = cfg_early_v;
    cfg_tol      = cfg_tol_v;
    for (int r = 0; r < N; r++) begin
      if (gaps && r > 0) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          b_in     = 16'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      b_in     = bvec[r];
      checkOutput("load_ready", in_ready, 1);
      last_accept_cyc = cyc;
      tick();
      if (r == 0) begin
        cfg_iter     = ~cfg_iter_v;
        cfg_early_en = ~cfg_early_v;
        cfg_tol      = ~cfg_tol_v;
      end
    end
    in_valid = 1'b0;
    b_in     = '0;
  endtask

  task automatic collectOutput(input bit rand_ready, input bit junk_in);
    int          budget;
    bit          first, done, stalled;
    logic [31:0] prev_x;
    logic        prev_last;
    exp_t        e;
    budget  = 20000;
    first   = 1;
    done    = 0;
    stalled = 0;
    prev_x  = '0;
    prev_last = 1'b0;
    while (!done && budget > 0) begin
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (junk_in) begin
        in_valid = 1'b1;
        b_in     = 16'($urandom);
      end
      checkOutput("in_ready_busy", in_ready, 0);
      if (!first) checkOutput("valid_held", out_valid, 1);
      if (stalled) begin
        checkOutput("hold_x", x_out, prev_x);
        checkOutput("hold_last", out_last, prev_last);
      end
      stalled = 0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("extra_output", sb.size(), 1);
          done = 1;
        end else begin
          if (first) begin
            checkOutput("latency", cyc - last_accept_cyc, sb[0].iters * N + 1);
            first = 0;
          end
          if (out_ready) begin
            e = sb.pop_front();
            checkOutput("x_out", x_out, e.x);
            checkOutput("out_last", out_last, e.last);
            checkOutput("out_iters", out_iters, e.iters);
            checkOutput("out_conv", out_conv, e.conv);
            if (e.last) done = 1;
          end else begin
            stalled   = 1;
            prev_x    = x_out;
            prev_last = out_last;
          end
        end
      end
      tick();
      budget--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("out_done", done, 1);
    checkOutput("valid_drop", out_valid, 0);
    checkOutput("idle_ready", in_ready, 1);
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_x_out", x_out, 0);
    checkOutput("rst_out_iters", out_iters, 0);
    checkOutput("rst_out_conv", out_conv, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("first_ready", in_ready, 1);

    // Single impulse, one iteration.
    $display("[TB] impulse, cfg_iter=0");
    for (int k = 0; k < N; k++) bvec[k] = '0;
    bvec[0] = 16'sd20;
    cfg_iter_v = 8'd0; cfg_early_v = 1'b0; cfg_tol_v = '0;
    applyStimulus(0);
    checkOutput("model_x0", exp_x[0], 32'h00010004);
    checkOutput("model_x1", exp_x[1], 32'h0000A66B);
    collectOutput(0, 0);

    $display("[TB] zero b, 5 iterations");
    for (int k = 0; k < N; k++) bvec[k] = '0;
    cfg_iter_v = 8'd5; cfg_early_v = 1'b0; cfg_tol_v = '0;
    applyStimulus(0);
    collectOutput(0, 0);

    $display("[TB] random b, 70 iterations, random backpressure");
    for (int k = 0; k < N; k++) bvec[k] = 16'($urandom);
    cfg_iter_v = 8'd70; cfg_early_v = 1'b0; cfg_tol_v = 32'hFFFF_FFFF;
    applyStimulus(0);
    collectOutput(1, 0);

    $display("[TB] constant b, early exit");
    for (int k = 0; k < N; k++) bvec[k] = 16'sd100;
    cfg_iter_v = 8'd200; cfg_early_v = 1'b1; cfg_tol_v = 32'h10;
    applyStimulus(0);
    collectOutput(0, 0);

    $display("[TB] load gaps, in_valid held while busy");
    for (int k = 0; k < N; k++) bvec[k] = 16'($urandom_range(0, 4000)) - 16'sd2000;
    cfg_iter_v = 8'd3; cfg_early_v = 1'b0; cfg_tol_v = '0;
    applyStimulus(1);
    collectOutput(1, 1);

    $display("[TB] reset in iteration 3 row 7");
    for (int k = 0; k < N; k++) bvec[k] = 16'($urandom);
    cfg_iter_v = 8'd10; cfg_early_v = 1'b0; cfg_tol_v = '0;
    applyStimulus(0);
    repeat (39) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_last", out_last, 0);
    checkOutput("mid_rst_x_out", x_out, 0);
    checkOutput("mid_rst_out_iters", out_iters, 0);
    checkOutput("mid_rst_out_conv", out_conv, 0);
    tick();
    checkOutput("mid_rst_idle", in_ready, 1);

    $display("[TB] problem after reset");
    for (int k = 0; k < N; k++) bvec[k] = 16'($urandom);
    cfg_iter_v = 8'd4; cfg_early_v = 1'b1; cfg_tol_v = 32'h0000_1000;
    applyStimulus(0);
    collectOutput(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
